regfile_access_ctrl: RTL and testbench
======================================

// Module: regfile_access_ctrl
// PURPOSE
//  Sequences all accesses to the 8x8 register file's single read and single write port.
//  Arbitrates between two requesters: CPU core and debug/loader port.
//  Splits 16-bit pair operations (pairs such as EF, GH) into two atomic byte cycles.
//  Sits between the requesters and the register file; it is the only driver of the register file port signals.
// PARAMETERS
//  ADDR_W  3  register address width (pair index = addr[ADDR_W-1:1])
//  DATA_W  8  register width; rdata/wdata are 2*DATA_W
// PORTS
//  clk            in   1         clock, all flops rising edge
//  reset_n        in   1         asynchronous, active-low reset
//  cpu_req        in   1         core request; hold high until cpu_ack
//  cpu_op         in   2         00 RD8, 01 WR8, 10 RD16, 11 WR16
//  cpu_addr       in   ADDR_W    register (8-bit ops) or pair, addr[0] ignored (16-bit ops)
//  cpu_wdata      in   2*DATA_W  WR8 uses [7:0]; WR16 uses hi=[15:8], lo=[7:0]
//  cpu_ack        out  1         one-cycle completion pulse
//  cpu_rdata      out  2*DATA_W  read result, valid while cpu_ack=1
//  dbg_req/dbg_op/dbg_addr/dbg_wdata/dbg_ack/dbg_rdata   same as cpu_* for the debug port
//  rf_read_addr   out  ADDR_W    to register file read address
//  rf_write_addr  out  ADDR_W    to register file write address
//  rf_data_in     out  DATA_W    to register file write data
//  rf_we          out  1         to register file write enable
//  rf_data_out    in   DATA_W    from register file (combinational read)
//  busy           out  1         1 when state != IDLE
//  grant_dbg      out  1         owner of the current transaction (0 core, 1 debug)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; rdata regs 0; round-robin pointer = core.
//  FSM: IDLE -> XFER_HI -> [XFER_LO if 16-bit] -> ACK -> IDLE.
//  IDLE: at an edge with any req=1, grant one requester. Latch op, addr and wdata at that edge.
//    Requesters may change operands after the grant; only req must be held.
//  XFER_HI: 8-bit op: addr = latched addr. 16-bit op: addr = {pair,0}.
//    rf_read_addr = rf_write_addr = addr.
//    WR: rf_we=1 and rf_data_in = wdata byte (WR8 [7:0], WR16 [15:8]).
//    RD: rdata byte is captured at the end of the cycle. RD8 -> rdata={0,byte}; RD16 -> hi byte.
//  XFER_LO: addr = {pair,1}; WR16 writes wdata[7:0]; RD16 captures the lo byte.
//  ACK: the granted port's ack=1 for exactly one cycle; its rdata is stable; rf_we=0; then IDLE.
//  rdata holds its value until the next read by the same port.
//  Latency from the grant edge to the ack cycle: 8-bit ops 2 cycles, 16-bit ops 3 cycles.
//    No back-to-back grants: IDLE always lasts at least 1 cycle.
//  A pair op is atomic: the other requester is never interleaved between the HI and LO cycles.
//  Outside XFER states: rf_we=0 and rf_read_addr/rf_write_addr/rf_data_in = 0.
//  A req deasserted before its ack is a protocol violation: the transaction still completes.
//  A req still high in the IDLE cycle after its ack starts a new transaction.
//  Reset mid-operation: abort immediately, no further rf_we and no ack.
//    A WR16 may be left half-written; the register file is reset in the same event.
//  Simultaneous requests in IDLE: resolved as described under CONFIGURATION.
// CONFIGURATION
//  Macro RFCTL_ROUND_ROBIN_EN:
//   - defined: round-robin. On a tie, the port not granted last wins; the pointer updates on each grant.
//   - undefined: fixed priority, core beats debug. The pointer flop is not built.
// STRUCTURE
//  rfctl_pkg: op encodings (OP_RD8, OP_WR8, OP_RD16, OP_WR16), FSM state enum, PORT_CPU/PORT_DBG.
//  Sub-module rfctl_arbiter: 2-way grant plus the optional round-robin pointer.
//  The top level holds the FSM, operand latches, address mux and rdata registers.
// TESTING
//  1. Reset, then cpu RD8 addr 0 -> cpu_ack 2 cycles after grant, cpu_rdata=16'h0080.
//  2. cpu WR16 pair 2 (addr 5), wdata 16'hBEEF -> rf_we on reg4=8'hBE, then reg5=8'hEF.
//     Then RD16 addr 4 -> 16'hBEEF.
//  3. cpu and dbg req in the same cycle, repeated 4 times:
//     without the macro, all cpu first; with the macro, grants alternate cpu,dbg,cpu,dbg.
//  4. dbg WR16 in progress while cpu requests in XFER_HI -> cpu granted only after dbg_ack;
//     no cpu access between the HI and LO writes.
//  5. reset_n low during XFER_HI of WR16 -> no rf_we thereafter, no ack;
//     after release: IDLE, outputs 0.
//  6. Hold cpu_req high across an ack -> a second transaction starts after one IDLE cycle;
//     operands changed after the grant are ignored.

Source files
------------

// File: rtl/rfctl_pkg.sv
// Shared definitions for the register-file access controller: operation codes,
// FSM states, port identifiers and default widths.
package rfctl_pkg;

  localparam int unsigned RFCTL_ADDR_W = 3;
  localparam int unsigned RFCTL_DATA_W = 8;

  typedef enum logic [1:0] {
    OP_RD8  = 2'b00,
    OP_WR8  = 2'b01,
    OP_RD16 = 2'b10,
    OP_WR16 = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_XFER_HI = 2'd1,
    ST_XFER_LO = 2'd2,
    ST_ACK     = 2'd3
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  function automatic logic op_is_pair(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_write(input op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/rfctl_arbiter.sv
// Two-way grant between core and debug port.
// RFCTL_ROUND_ROBIN_EN selects round-robin on ties; otherwise the core always wins.
module rfctl_arbiter
  import rfctl_pkg::*;
(
`ifdef RFCTL_ROUND_ROBIN_EN
  input  logic clk,
  input  logic reset_n,
`endif
  input  logic grant_en,
  input  logic cpu_req,
  input  logic dbg_req,
  output logic gnt_valid_c,
  output logic gnt_dbg_c
);

`ifdef RFCTL_ROUND_ROBIN_EN
  // Pointer names the port that wins the next tie; it flips away from each winner.
  logic prefer_dbg_q, prefer_dbg_d;

  always_comb begin
    gnt_valid_c  = grant_en & (cpu_req | dbg_req);
    gnt_dbg_c    = dbg_req & (~cpu_req | prefer_dbg_q);
    prefer_dbg_d = prefer_dbg_q;
    if (gnt_valid_c) begin
      prefer_dbg_d = (gnt_dbg_c == PORT_DBG) ? PORT_CPU : PORT_DBG;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prefer_dbg_q <= PORT_CPU;
    end else begin
      prefer_dbg_q <= prefer_dbg_d;
    end
  end
`else
  always_comb begin
    gnt_valid_c = grant_en & (cpu_req | dbg_req);
    gnt_dbg_c   = dbg_req & ~cpu_req;
  end
`endif

endmodule

// File: rtl/regfile_access_ctrl.sv
// Sequences core/debug accesses onto the register file's single read and write port,
// splitting pair operations into two atomic byte cycles. Tie policy: RFCTL_ROUND_ROBIN_EN.
module regfile_access_ctrl
  import rfctl_pkg::*;
#(
  parameter int unsigned ADDR_W = RFCTL_ADDR_W,
  parameter int unsigned DATA_W = RFCTL_DATA_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cpu_req,
  input  logic [1:0]          cpu_op,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [2*DATA_W-1:0] cpu_wdata,
  output logic                cpu_ack,
  output logic [2*DATA_W-1:0] cpu_rdata,
  input  logic                dbg_req,
  input  logic [1:0]          dbg_op,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [2*DATA_W-1:0] dbg_wdata,
  output logic                dbg_ack,
  output logic [2*DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0]   rf_read_addr,
  output logic [ADDR_W-1:0]   rf_write_addr,
  output logic [DATA_W-1:0]   rf_data_in,
  output logic                rf_we,
  input  logic [DATA_W-1:0]   rf_data_out,
  output logic                busy,
  output logic                grant_dbg
);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2*DATA_W-1:0] wdata_q, wdata_d;
  logic                own_q, own_d;
  logic [2*DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [2*DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]   rf_data_in_q, rf_data_in_d;
  logic                rf_we_q, rf_we_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                dbg_ack_q, dbg_ack_d;
  logic                busy_q, busy_d;

  logic                arb_en_c, gnt_valid_c, gnt_dbg_c;
  logic                capture;
  logic [2*DATA_W-1:0] rdata_old, rdata_new;

  assign arb_en_c = (state_q == ST_IDLE);

  rfctl_arbiter u_arbiter (
`ifdef RFCTL_ROUND_ROBIN_EN
    .clk         (clk),
    .reset_n     (reset_n),
`endif
    .grant_en    (arb_en_c),
    .cpu_req     (cpu_req),
    .dbg_req     (dbg_req),
    .gnt_valid_c (gnt_valid_c),
    .gnt_dbg_c   (gnt_dbg_c)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    own_d       = own_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    capture     = 1'b0;
    rdata_old   = own_q ? dbg_rdata_q : cpu_rdata_q;
    rdata_new   = rdata_old;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid_c) begin
          state_d = ST_XFER_HI;
          own_d   = gnt_dbg_c;
          op_d    = gnt_dbg_c ? op_e'(dbg_op) : op_e'(cpu_op);
          addr_d  = gnt_dbg_c ? dbg_addr : cpu_addr;
          wdata_d = gnt_dbg_c ? dbg_wdata : cpu_wdata;
        end
      end
      ST_XFER_HI: begin
        state_d   = op_is_pair(op_q) ? ST_XFER_LO : ST_ACK;
        capture   = !op_is_write(op_q);
        rdata_new = op_is_pair(op_q) ? {rf_data_out, rdata_old[DATA_W-1:0]}
                                     : {DATA_W'(0), rf_data_out};
      end
      ST_XFER_LO: begin
        state_d   = ST_ACK;
        capture   = !op_is_write(op_q);
        rdata_new = {rdata_old[2*DATA_W-1:DATA_W], rf_data_out};
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      if (own_q) dbg_rdata_d = rdata_new;
      else       cpu_rdata_d = rdata_new;
    end

    // Port outputs are decoded from the state being entered so they register cleanly.
    rf_addr_d    = '0;
    rf_data_in_d = '0;
    rf_we_d      = 1'b0;
    case (state_d)
      ST_XFER_HI: begin
        rf_addr_d = op_is_pair(op_d) ? {addr_d[ADDR_W-1:1], 1'b0} : addr_d;
        rf_we_d   = op_is_write(op_d);
        if (rf_we_d) begin
          rf_data_in_d = op_is_pair(op_d) ? wdata_d[2*DATA_W-1:DATA_W] : wdata_d[DATA_W-1:0];
        end
      end
      ST_XFER_LO: begin
        rf_addr_d = {addr_d[ADDR_W-1:1], 1'b1};
        rf_we_d   = op_is_write(op_d);
        if (rf_we_d) rf_data_in_d = wdata_d[DATA_W-1:0];
      end
      default: ;
    endcase

    cpu_ack_d = (state_d == ST_ACK) && (own_d == PORT_CPU);
    dbg_ack_d = (state_d == ST_ACK) && (own_d == PORT_DBG);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_RD8;
      addr_q       <= '0;
      wdata_q      <= '0;
      own_q        <= PORT_CPU;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      rf_addr_q    <= '0;
      rf_data_in_q <= '0;
      rf_we_q      <= 1'b0;
      cpu_ack_q    <= 1'b0;
      dbg_ack_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      own_q        <= own_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_in_q <= rf_data_in_d;
      rf_we_q      <= rf_we_d;
      cpu_ack_q    <= cpu_ack_d;
      dbg_ack_q    <= dbg_ack_d;
      busy_q       <= busy_d;
    end
  end

  assign cpu_ack       = cpu_ack_q;
  assign dbg_ack       = dbg_ack_q;
  assign cpu_rdata     = cpu_rdata_q;
  assign dbg_rdata     = dbg_rdata_q;
  assign rf_read_addr  = rf_addr_q;
  assign rf_write_addr = rf_addr_q;
  assign rf_data_in    = rf_data_in_q;
  assign rf_we         = rf_we_q;
  assign busy          = busy_q;
  assign grant_dbg     = own_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl: a behavioural register-file/ordering
// model predicts read data, write sequences, latencies and arbitration outcomes.
module tb_regfile_access_ctrl;

  localparam logic [1:0] RD8 = 2'b00, WR8 = 2'b01, RD16 = 2'b10, WR16 = 2'b11;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, dbg_req;
  logic [1:0]  cpu_op, dbg_op;
  logic [2:0]  cpu_addr, dbg_addr;
  logic [15:0] cpu_wdata, dbg_wdata;
  logic        cpu_ack, dbg_ack;
  logic [15:0] cpu_rdata, dbg_rdata;
  logic [2:0]  rf_read_addr, rf_write_addr;
  logic [7:0]  rf_data_in, rf_data_out;
  logic        rf_we, busy, grant_dbg;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int ack_cnt = 0;

  logic [7:0]  rf_mem [8];
  logic [7:0]  m_rf   [8];
  logic [15:0] m_last [2];
  logic [11:0] wr_log [$];
  logic [11:0] exp_wr [$];
`ifdef RFCTL_ROUND_ROBIN_EN
  logic        m_prefer_dbg;
`endif

  always #5 clk = ~clk;

  regfile_access_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cpu_req       (cpu_req),
    .cpu_op        (cpu_op),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_ack       (cpu_ack),
    .cpu_rdata     (cpu_rdata),
    .dbg_req       (dbg_req),
    .dbg_op        (dbg_op),
    .dbg_addr      (dbg_addr),
    .dbg_wdata     (dbg_wdata),
    .dbg_ack       (dbg_ack),
    .dbg_rdata     (dbg_rdata),
    .rf_read_addr  (rf_read_addr),
    .rf_write_addr (rf_write_addr),
    .rf_data_in    (rf_data_in),
    .rf_we         (rf_we),
    .rf_data_out   (rf_data_out),
    .busy          (busy),
    .grant_dbg     (grant_dbg)
  );

  // Register file environment: resets with the controller, reg i = 8'h80 + i.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= 8'h80 + 8'(i);
    end else if (rf_we) begin
      rf_mem[rf_write_addr] <= rf_data_in;
    end
  end
  assign rf_data_out = rf_mem[rf_read_addr];

  always @(negedge clk) begin
    if (rf_we) begin
      wr_log.push_back({grant_dbg, rf_write_addr, rf_data_in});
      we_cnt++;
    end
    if (cpu_ack || dbg_ack) ack_cnt++;
    if (busy) begin
      checks++;
      if (rf_read_addr !== rf_write_addr) begin
        errors++;
        $display("FAIL rf_addr_match: read %0d write %0d", rf_read_addr, rf_write_addr);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 8'h80 + 8'(i);
    m_last[0] = 16'h0;
    m_last[1] = 16'h0;
`ifdef RFCTL_ROUND_ROBIN_EN
    m_prefer_dbg = 1'b0;
`endif
  endtask

  // Expected port rdata after the ack of one transaction applied to the model.
  task automatic model_txn(input logic port, input logic [1:0] op, input logic [2:0] addr,
                           input logic [15:0] wd, output logic [15:0] exp_rd);
    logic [2:0] hi_a, lo_a;
    hi_a = {addr[2:1], 1'b0};
    lo_a = {addr[2:1], 1'b1};
    case (op)
      RD8:  m_last[port] = {8'h00, m_rf[addr]};
      WR8: begin
        m_rf[addr] = wd[7:0];
        exp_wr.push_back({port, addr, wd[7:0]});
      end
      RD16: m_last[port] = {m_rf[hi_a], m_rf[lo_a]};
      default: begin
        m_rf[hi_a] = wd[15:8];
        exp_wr.push_back({port, hi_a, wd[15:8]});
        m_rf[lo_a] = wd[7:0];
        exp_wr.push_back({port, lo_a, wd[7:0]});
      end
    endcase
    exp_rd = m_last[port];
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cpu_req = 1'b0; dbg_req = 1'b0;
    cpu_op = RD8; dbg_op = RD8;
    cpu_addr = '0; dbg_addr = '0;
    cpu_wdata = '0; dbg_wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    wr_log.delete();
    exp_wr.delete();
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives one request at a negedge and waits (bounded) for that port's ack.
  task automatic run_txn(input logic port, input logic [1:0] op, input logic [2:0] addr,
                         input logic [15:0] wd, input bit keep, input bit scramble,
                         output logic [15:0] rd, output int lat, output bit ok,
                         output bit idle0);
    int n;
    @(negedge clk);
    idle0 = !busy;
    if (port) begin dbg_req = 1'b1; dbg_op = op; dbg_addr = addr; dbg_wdata = wd; end
    else      begin cpu_req = 1'b1; cpu_op = op; cpu_addr = addr; cpu_wdata = wd; end
    ok = 1'b0; n = 0; rd = '0; lat = 0;
    while (!ok && n < 40) begin
      @(negedge clk);
      n++;
      if (port ? dbg_ack : cpu_ack) begin
        ok  = 1'b1;
        lat = n;
        rd  = port ? dbg_rdata : cpu_rdata;
`ifdef RFCTL_ROUND_ROBIN_EN
        m_prefer_dbg = !port;
`endif
      end else if (scramble && busy && grant_dbg == port) begin
        if (port) begin dbg_op = 2'($urandom); dbg_addr = 3'($urandom); dbg_wdata = 16'($urandom); end
        else      begin cpu_op = 2'($urandom); cpu_addr = 3'($urandom); cpu_wdata = 16'($urandom); end
      end
    end
    if (!keep) begin
      if (port) dbg_req = 1'b0;
      else      cpu_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, grant_dbg, cpu_ack, dbg_ack} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {busy, grant_dbg, cpu_ack, dbg_ack});
    end
    checks++;
    if ({rf_we, rf_read_addr, rf_write_addr, rf_data_in} !== 15'h0) begin
      errors++; $display("FAIL reset_rf: we %b ra %0d wa %0d din %h", rf_we, rf_read_addr, rf_write_addr, rf_data_in);
    end
    checks++;
    if ({cpu_rdata, dbg_rdata} !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: cpu %h dbg %h want 0", cpu_rdata, dbg_rdata);
    end
  endtask

  task automatic test_rd8();
    logic [15:0] rd, exp; int lat; bit ok, i0;
    run_txn(1'b0, RD8, 3'd0, 16'h0, 1'b0, 1'b0, rd, lat, ok, i0);
    model_txn(1'b0, RD8, 3'd0, 16'h0, exp);
    checks++;
    if (!ok || lat != 2) begin errors++; $display("FAIL rd8_latency: ok %0b lat %0d want 2", ok, lat); end
    checks++;
    if (rd !== 16'h0080 || rd !== exp) begin errors++; $display("FAIL rd8_data: got %h want 0080", rd); end
  endtask

  task automatic test_wr16_pair();
    logic [15:0] rd, exp; int lat; bit ok, i0;
    wr_log.delete(); exp_wr.delete();
    run_txn(1'b0, WR16, 3'd5, 16'hBEEF, 1'b0, 1'b0, rd, lat, ok, i0);
    model_txn(1'b0, WR16, 3'd5, 16'hBEEF, exp);
    checks++;
    if (!ok || lat != 3) begin errors++; $display("FAIL wr16_latency: ok %0b lat %0d want 3", ok, lat); end
    checks++;
    if (wr_log.size() != 2 || wr_log[0] !== {1'b0, 3'd4, 8'hBE} || wr_log[1] !== {1'b0, 3'd5, 8'hEF}) begin
      errors++; $display("FAIL wr16_writes: %0d writes, first %h want 4be then 5ef", wr_log.size(), wr_log.size() > 0 ? wr_log[0] : 12'h0);
    end
    run_txn(1'b0, RD16, 3'd4, 16'h0, 1'b0, 1'b0, rd, lat, ok, i0);
    model_txn(1'b0, RD16, 3'd4, 16'h0, exp);
    checks++;
    if (!ok || rd !== 16'hBEEF || rd !== exp || lat != 3) begin
      errors++; $display("FAIL rd16_pair: ok %0b data %h lat %0d want beef lat 3", ok, rd, lat);
    end
  endtask

  task automatic test_arbitration();
    logic [15:0] r0, r1, e0, e1; int l0, l1; bit ok0, ok1, i0, i1;
    logic winner; logic [2:0] a0, a1;
    for (int rep = 0; rep < 4; rep++) begin
`ifdef RFCTL_ROUND_ROBIN_EN
      winner = m_prefer_dbg;
`else
      winner = 1'b0;
`endif
      a0 = 3'($urandom); a1 = 3'($urandom);
      fork
        run_txn(1'b0, RD8, a0, 16'h0, 1'b0, 1'b0, r0, l0, ok0, i0);
        run_txn(1'b1, RD8, a1, 16'h0, 1'b0, 1'b0, r1, l1, ok1, i1);
      join
      model_txn(1'b0, RD8, a0, 16'h0, e0);
      model_txn(1'b1, RD8, a1, 16'h0, e1);
      checks++;
      if (!ok0 || !ok1 || (winner ? l1 : l0) != 2 || (winner ? l0 : l1) != 5) begin
        errors++; $display("FAIL arb_order rep %0d: cpu lat %0d dbg lat %0d winner should be %0d", rep, l0, l1, winner);
      end
      checks++;
      if (r0 !== e0 || r1 !== e1) begin
        errors++; $display("FAIL arb_data rep %0d: cpu %h/%h dbg %h/%h", rep, r0, e0, r1, e1);
      end
    end
  endtask

  task automatic test_atomic();
    logic [15:0] rd0, rd1, e0, e1, wd; int l0, l1, n; bit ok0, ok1, i0, i1, found;
    logic [2:0] pa;
    wr_log.delete(); exp_wr.delete();
    pa = {2'($urandom), 1'b0};
    wd = 16'($urandom);
    found = 1'b0;
    fork
      run_txn(1'b1, WR16, pa, wd, 1'b0, 1'b0, rd1, l1, ok1, i1);
      begin
        n = 0;
        while (!found && n < 10) begin
          @(posedge clk); #1; n++;
          if (busy && grant_dbg && rf_we) found = 1'b1;
        end
        run_txn(1'b0, WR8, pa, 16'h00A5, 1'b0, 1'b0, rd0, l0, ok0, i0);
      end
    join
    model_txn(1'b1, WR16, pa, wd, e1);
    model_txn(1'b0, WR8, pa, 16'h00A5, e0);
    checks++;
    if (!found || !ok0 || !ok1 || l1 != 3 || l0 != 5) begin
      errors++; $display("FAIL atomic_timing: found %0b dbg lat %0d cpu lat %0d want 3/5", found, l1, l0);
    end
    checks++;
    if (wr_log.size() != exp_wr.size()) begin
      errors++; $display("FAIL atomic_count: got %0d writes want %0d", wr_log.size(), exp_wr.size());
    end else begin
      foreach (exp_wr[k]) if (wr_log[k] !== exp_wr[k]) begin
        errors++; $display("FAIL atomic_seq %0d: got %h want %h", k, wr_log[k], exp_wr[k]);
      end
    end
    run_txn(1'b0, RD16, pa, 16'h0, 1'b0, 1'b0, rd0, l0, ok0, i0);
    model_txn(1'b0, RD16, pa, 16'h0, e0);
    checks++;
    if (!ok0 || rd0 !== e0) begin errors++; $display("FAIL atomic_readback: got %h want %h", rd0, e0); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd, exp; int lat, n, we0, ack0; bit ok, i0, found;
    @(negedge clk);
    cpu_req = 1'b1; cpu_op = WR16; cpu_addr = 3'd2; cpu_wdata = 16'h1234;
    found = 1'b0; n = 0;
    while (!found && n < 10) begin
      @(posedge clk); #1; n++;
      if (busy && rf_we) found = 1'b1;
    end
    we0 = we_cnt; ack0 = ack_cnt;
    reset_n = 1'b0;
    cpu_req = 1'b0;
    model_reset();
    #1;
    checks++;
    if (!found || busy !== 1'b0 || rf_we !== 1'b0) begin
      errors++; $display("FAIL reset_abort: found %0b busy %b we %b want 0", found, busy, rf_we);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wr_log.delete(); exp_wr.delete();
    repeat (4) @(negedge clk);
    checks++;
    if (we_cnt != we0 || ack_cnt != ack0) begin
      errors++; $display("FAIL reset_quiet: writes %0d acks %0d want 0/0", we_cnt - we0, ack_cnt - ack0);
    end
    checks++;
    if ({busy, cpu_ack, dbg_ack, rf_we, rf_read_addr, rf_data_in, cpu_rdata} !== 31'h0) begin
      errors++; $display("FAIL reset_outputs: busy %b we %b addr %0d rdata %h", busy, rf_we, rf_read_addr, cpu_rdata);
    end
    run_txn(1'b0, RD16, 3'd2, 16'h0, 1'b0, 1'b0, rd, lat, ok, i0);
    model_txn(1'b0, RD16, 3'd2, 16'h0, exp);
    checks++;
    if (!ok || rd !== exp) begin errors++; $display("FAIL reset_readback: got %h want %h", rd, exp); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd, rd2, exp, exp2, wd; int lat, lat2; bit ok, ok2, i0, idle;
    logic [2:0] pa;
    wr_log.delete(); exp_wr.delete();
    pa = {2'($urandom), 1'b1};
    wd = 16'($urandom);
    run_txn(1'b0, WR16, pa, wd, 1'b1, 1'b1, rd, lat, ok, i0);
    model_txn(1'b0, WR16, pa, wd, exp);
    run_txn(1'b0, RD16, pa, 16'h0, 1'b0, 1'b0, rd2, lat2, ok2, idle);
    model_txn(1'b0, RD16, pa, 16'h0, exp2);
    checks++;
    if (!ok || lat != 3 || rd !== exp) begin
      errors++; $display("FAIL hold_first: ok %0b lat %0d rdata %h want lat 3 rdata %h", ok, lat, rd, exp);
    end
    checks++;
    if (!idle || !ok2 || lat2 != 3) begin
      errors++; $display("FAIL hold_restart: idle %0b lat %0d want idle 1 lat 3", idle, lat2);
    end
    checks++;
    if (rd2 !== exp2 || wr_log.size() != 2 || wr_log[0] !== exp_wr[0] || wr_log[1] !== exp_wr[1]) begin
      errors++; $display("FAIL hold_operands: read %h want %h, %0d writes", rd2, exp2, wr_log.size());
    end
  endtask

  task automatic test_random();
    logic [15:0] rd, exp, wd; int lat; bit ok, i0;
    logic port; logic [1:0] op; logic [2:0] a;
    wr_log.delete(); exp_wr.delete();
    for (int t = 0; t < 24; t++) begin
      port = 1'($urandom); op = 2'($urandom); a = 3'($urandom); wd = 16'($urandom);
      run_txn(port, op, a, wd, 1'b0, 1'b0, rd, lat, ok, i0);
      model_txn(port, op, a, wd, exp);
      checks++;
      if (!ok || rd !== exp || lat != (op[1] ? 3 : 2)) begin
        errors++; $display("FAIL random_txn %0d: port %0d op %0d addr %0d rdata %h want %h lat %0d", t, port, op, a, rd, exp, lat);
      end
    end
    checks++;
    if (wr_log.size() != exp_wr.size()) begin
      errors++; $display("FAIL random_writes: got %0d writes want %0d", wr_log.size(), exp_wr.size());
    end else begin
      foreach (exp_wr[k]) if (wr_log[k] !== exp_wr[k]) begin
        errors++; $display("FAIL random_write_seq %0d: got %h want %h", k, wr_log[k], exp_wr[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rd8();
    test_wr16_pair();
    test_arbitration();
    test_atomic();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
